pll_supervisor: RTL and testbench
=================================

PLL_SUPERVISOR -- requirements
Module: pll_supervisor

Interface
REQ-001 The block SHALL have parameter N_DOM, default 3: number of sequenced domain resets (1..8).
REQ-002 The block SHALL have parameter RST_PULSE_CYC, default 16: PLL reset pulse length in cycles (>=1).
REQ-003 The block SHALL have parameter LOCK_TIMEOUT_CYC, default 65536: maximum wait for lock per attempt.
REQ-004 The block SHALL have parameter LOCK_STABLE_CYC, default 1024: number of consecutive synchronised-locked cycles required before release.
REQ-005 The block SHALL have parameter LOSS_FILT_CYC, default 8: number of consecutive synchronised-unlocked cycles in RUN that count as a lock loss.
REQ-006 The block SHALL have parameter SEQ_GAP_CYC, default 32: cycles between successive domain reset releases (>=1).
REQ-007 The block SHALL have parameter MAX_RETRY, default 3: failed attempts allowed per reference before switching reference or declaring a fault.
REQ-008 The block SHALL have parameter SWITCH_EN, default 1: 1 enables reference-clock switchover, 0 disables it.
REQ-009 The block SHALL have port refclk, input, width 1: free-running supervisor clock that is not sourced from the supervised PLL.
REQ-010 The block SHALL have port rst_n, input, width 1: asynchronous, active-low reset.
REQ-011 The block SHALL have port pll_locked, input, width 1: PLL locked, asynchronous to refclk.
REQ-012 The block SHALL have port pll_rst, output, width 1: PLL reset, active-high.
REQ-013 The block SHALL have port extswitch, output, width 1: one-cycle pulse requesting a PLL reference switch.
REQ-014 The block SHALL have port clk_sel, output, width 1: currently selected reference (0 = primary, 1 = alternate).
REQ-015 The block SHALL have port dom_rst_n, output, width N_DOM: per-domain resets, active-low.
REQ-016 The block SHALL have port state, output, width 3: FSM state encoding.
REQ-017 The block SHALL have port retry_cnt, output, width 4: failed attempts on the current reference.
REQ-018 The block SHALL have port loss_cnt, output, width 16: lock-loss events, saturating at 0xFFFF.
REQ-019 The block SHALL have port fault, output, width 1: sticky unrecoverable-failure flag.

Function
REQ-020 pll_locked SHALL pass through a 2-flop synchroniser (lk_s); all decisions SHALL use lk_s, giving 2 cycles of input latency.
REQ-021 The FSM states SHALL be encoded as PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, SWITCH=5, FAULT=6.
REQ-022 PLL_RST: pll_rst=1 for exactly RST_PULSE_CYC cycles, then the FSM SHALL go to WAIT_LOCK with pll_rst=0.
REQ-023 WAIT_LOCK: on lk_s=1 the FSM SHALL go to STABLE; after LOCK_TIMEOUT_CYC cycles without lock it SHALL take the attempt-failure path (REQ-026).
REQ-024 STABLE: the stable counter SHALL count consecutive lk_s=1 cycles.
  - lk_s=0 SHALL restart the counter and return the FSM to WAIT_LOCK; the timeout does not reset.
  - Reaching LOCK_STABLE_CYC SHALL move the FSM to RELEASE and clear retry_cnt.
REQ-025 RELEASE: dom_rst_n[0] SHALL deassert on the first RELEASE cycle, and dom_rst_n[i] SHALL deassert SEQ_GAP_CYC cycles after bit i-1.
  - After bit N_DOM-1 is released the FSM SHALL go to RUN.
  - A lock loss during RELEASE SHALL be handled as in RUN.
REQ-026 Attempt failure SHALL increment retry_cnt.
  - If retry_cnt reaches MAX_RETRY, SWITCH_EN=1 and the alternate reference has not yet been tried: go to SWITCH.
  - If retry_cnt reaches MAX_RETRY otherwise: go to FAULT.
  - Else: go to PLL_RST.
REQ-027 SWITCH SHALL last one cycle.
  - In that cycle: extswitch=1, clk_sel toggles, retry_cnt=0, and the alternate-tried flag is set.
  - The next state SHALL be PLL_RST.
REQ-028 RUN/RELEASE: LOSS_FILT_CYC consecutive lk_s=0 cycles SHALL trigger a lock loss.
  - A shorter low glitch SHALL be ignored and SHALL reset the filter.
REQ-029 On a lock loss, in the same cycle, the block SHALL drive all dom_rst_n=0, increment loss_cnt (saturating), clear the alternate-tried flag, and set next state PLL_RST.
  - clk_sel SHALL be kept.
REQ-030 FAULT: pll_rst=1, dom_rst_n all 0 and fault=1.
  - FAULT is terminal until rst_n.
  - pll_locked SHALL be ignored in FAULT.
REQ-031 dom_rst_n SHALL be all 0 in every state except RELEASE (partial) and RUN (all 1).
REQ-032 extswitch SHALL be 0 except in SWITCH; it SHALL never be high for two consecutive cycles.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 While rst_n=0, outputs SHALL immediately take: state=PLL_RST, pll_rst=1, extswitch=0, clk_sel=0, dom_rst_n=0, retry_cnt=0, loss_cnt=0, fault=0.
  - The synchroniser and all counters SHALL be cleared.
REQ-035 After rst_n deasserts, the first PLL_RST pulse SHALL last a full RST_PULSE_CYC cycles.
REQ-036 Reset asserted in any state, including mid-RELEASE, SHALL abort the sequence with no extswitch pulse.

Verification (RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=20, LOCK_STABLE_CYC=8, LOSS_FILT_CYC=3, SEQ_GAP_CYC=2, MAX_RETRY=2, N_DOM=3)
REQ-037 Nominal bring-up: pll_locked held 1 from reset release -> pll_rst high 4 cycles; dom_rst_n steps 000->001->011->111 at 2-cycle spacing; state=RUN; retry_cnt=0.
REQ-038 Glitches: 2-cycle low on pll_locked in RUN -> no change, loss_cnt=0. 3-cycle low -> dom_rst_n=000 the same cycle filter completes, loss_cnt=1, state=PLL_RST, clk_sel unchanged.
REQ-039 Switchover: pll_locked stuck 0 -> two timeouts, then one extswitch pulse and clk_sel=1; raise lock afterwards -> normal release with clk_sel=1.
REQ-040 Fault: pll_locked stuck 0 with SWITCH_EN=1 -> 2 fails, switch, 2 fails, fault=1, state=FAULT; later lock has no effect. With SWITCH_EN=0 -> FAULT after 2 fails, extswitch never pulsed.
REQ-041 Unstable lock: lock toggling every 5 cycles in STABLE -> never reaches RELEASE, timeout retries counted.
REQ-042 Reset mid-RELEASE: rst_n pulsed low after dom_rst_n=001 -> all outputs at reset values asynchronously; sequence restarts from PLL_RST.

Source files
------------

// File: rtl/pll_supervisor.sv
// PLL supervisor: pulses the PLL reset, qualifies lock, sequences domain resets and
// retries, switches reference or faults when lock cannot be obtained or held.
module pll_supervisor #(
   parameter int N_DOM            = 3,
   parameter int RST_PULSE_CYC    = 16,
   parameter int LOCK_TIMEOUT_CYC = 65536,
   parameter int LOCK_STABLE_CYC  = 1024,
   parameter int LOSS_FILT_CYC    = 8,
   parameter int SEQ_GAP_CYC      = 32,
   parameter int MAX_RETRY        = 3,
   parameter int SWITCH_EN        = 1
) (
   input  logic             refclk,
   input  logic             rst_n,
   input  logic             pll_locked,
   output logic             pll_rst,
   output logic             extswitch,
   output logic             clk_sel,
   output logic [N_DOM-1:0] dom_rst_n,
   output logic [2:0]       state,
   output logic [3:0]       retry_cnt,
   output logic [15:0]      loss_cnt,
   output logic             fault
);

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4,
      SWITCH    = 3'd5,
      FAULT     = 3'd6
   } state_e;

   localparam int CYC_MAX = (RST_PULSE_CYC > SEQ_GAP_CYC) ? RST_PULSE_CYC : SEQ_GAP_CYC;
   localparam int CW      = $clog2(CYC_MAX + 1);
   localparam int TW      = $clog2(LOCK_TIMEOUT_CYC + 1);
   localparam int SW      = $clog2(LOCK_STABLE_CYC + 1);
   localparam int FW      = $clog2(LOSS_FILT_CYC + 1);

   localparam logic [CW-1:0] CYC_ONE     = CW'(1);
   localparam logic [CW-1:0] PULSE_LAST  = CW'(RST_PULSE_CYC - 1);
   localparam logic [CW-1:0] GAP_LAST    = CW'(SEQ_GAP_CYC - 1);
   localparam logic [TW-1:0] TO_ONE      = TW'(1);
   localparam logic [TW-1:0] TO_LAST     = TW'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [SW-1:0] STAB_ONE    = SW'(1);
   localparam logic [SW-1:0] STAB_LAST   = SW'(LOCK_STABLE_CYC - 1);
   localparam logic [FW-1:0] FILT_ONE    = FW'(1);
   localparam logic [FW-1:0] FILT_LAST   = FW'(LOSS_FILT_CYC - 1);
   localparam logic [3:0]    N_DOM_W     = 4'(N_DOM);
   localparam logic [3:0]    RETRY_MAX_W = 4'(MAX_RETRY);

   logic             lk_meta_q, lk_s_q;
   state_e           state_q, state_d;
   logic [CW-1:0]    cyc_q, cyc_d;
   logic [TW-1:0]    to_q, to_d;
   logic [SW-1:0]    stab_q, stab_d;
   logic [FW-1:0]    filt_q, filt_d;
   logic [3:0]       rel_q, rel_d;
   logic             alt_q, alt_d;
   logic [3:0]       retry_q, retry_d;
   logic [15:0]      loss_q, loss_d;
   logic             clk_sel_q, clk_sel_d;
   logic             pll_rst_q, pll_rst_d;
   logic             extswitch_q, extswitch_d;
   logic             fault_q, fault_d;
   logic [N_DOM-1:0] dom_q, dom_d;
   logic [3:0]       retry_inc_s;
   logic             loss_hit_s, lost_s, failed_s;

   // Two-flop synchroniser for the asynchronous lock indication
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         lk_meta_q <= 1'b0;
         lk_s_q    <= 1'b0;
      end else begin
         lk_meta_q <= pll_locked;
         lk_s_q    <= lk_meta_q;
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= PLL_RST;
         cyc_q       <= {CW{1'b0}};
         to_q        <= {TW{1'b0}};
         stab_q      <= {SW{1'b0}};
         filt_q      <= {FW{1'b0}};
         rel_q       <= 4'd0;
         alt_q       <= 1'b0;
         retry_q     <= 4'd0;
         loss_q      <= 16'd0;
         clk_sel_q   <= 1'b0;
         pll_rst_q   <= 1'b1;
         extswitch_q <= 1'b0;
         fault_q     <= 1'b0;
         dom_q       <= {N_DOM{1'b0}};
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         to_q        <= to_d;
         stab_q      <= stab_d;
         filt_q      <= filt_d;
         rel_q       <= rel_d;
         alt_q       <= alt_d;
         retry_q     <= retry_d;
         loss_q      <= loss_d;
         clk_sel_q   <= clk_sel_d;
         pll_rst_q   <= pll_rst_d;
         extswitch_q <= extswitch_d;
         fault_q     <= fault_d;
         dom_q       <= dom_d;
      end
   end

   // Next state; outputs are decoded from the next state so they line up with state_q
   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      to_d        = to_q;
      stab_d      = stab_q;
      filt_d      = {FW{1'b0}};
      rel_d       = rel_q;
      alt_d       = alt_q;
      retry_d     = retry_q;
      loss_d      = loss_q;
      clk_sel_d   = clk_sel_q;
      retry_inc_s = retry_q + 4'd1;
      loss_hit_s  = 1'b0;
      lost_s      = 1'b0;
      failed_s    = 1'b0;

      if ((state_q == RELEASE) || (state_q == RUN)) begin
         if (lk_s_q) begin
            filt_d = {FW{1'b0}};
         end else if (filt_q == FILT_LAST) begin
            loss_hit_s = 1'b1;
         end else begin
            filt_d = filt_q + FILT_ONE;
         end
      end else begin
         filt_d = {FW{1'b0}};
      end

      case (state_q)
         PLL_RST: begin
            if (cyc_q == PULSE_LAST) begin
               state_d = WAIT_LOCK;
               cyc_d   = {CW{1'b0}};
               to_d    = {TW{1'b0}};
            end else begin
               cyc_d = cyc_q + CYC_ONE;
            end
         end
         WAIT_LOCK: begin
            // The attempt timer only counts unlocked cycles and survives STABLE drop-outs
            if (lk_s_q) begin
               state_d = STABLE;
               stab_d  = {SW{1'b0}};
            end else if (to_q == TO_LAST) begin
               failed_s = 1'b1;
            end else begin
               to_d = to_q + TO_ONE;
            end
         end
         STABLE: begin
            if (!lk_s_q) begin
               state_d = WAIT_LOCK;
               stab_d  = {SW{1'b0}};
            end else if (stab_q == STAB_LAST) begin
               state_d = RELEASE;
               retry_d = 4'd0;
               rel_d   = 4'd1;
               cyc_d   = {CW{1'b0}};
            end else begin
               stab_d = stab_q + STAB_ONE;
            end
         end
         RELEASE: begin
            if (loss_hit_s) begin
               lost_s = 1'b1;
            end else if (rel_q >= N_DOM_W) begin
               state_d = RUN;
            end else if (cyc_q == GAP_LAST) begin
               cyc_d = {CW{1'b0}};
               rel_d = rel_q + 4'd1;
               if ((rel_q + 4'd1) == N_DOM_W) begin
                  state_d = RUN;
               end else begin
                  state_d = RELEASE;
               end
            end else begin
               cyc_d = cyc_q + CYC_ONE;
            end
         end
         RUN: begin
            if (loss_hit_s) begin
               lost_s = 1'b1;
            end else begin
               state_d = RUN;
            end
         end
         SWITCH: begin
            state_d = PLL_RST;
            cyc_d   = {CW{1'b0}};
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: begin
            state_d = PLL_RST;
            cyc_d   = {CW{1'b0}};
         end
      endcase

      case ({lost_s, failed_s})
         2'b10: begin
            state_d = PLL_RST;
            cyc_d   = {CW{1'b0}};
            alt_d   = 1'b0;
            if (loss_q != 16'hFFFF) begin
               loss_d = loss_q + 16'd1;
            end else begin
               loss_d = loss_q;
            end
         end
         2'b01: begin
            retry_d = retry_inc_s;
            cyc_d   = {CW{1'b0}};
            if (retry_inc_s >= RETRY_MAX_W) begin
               if ((SWITCH_EN != 0) && !alt_q) begin
                  state_d   = SWITCH;
                  retry_d   = 4'd0;
                  clk_sel_d = ~clk_sel_q;
                  alt_d     = 1'b1;
               end else begin
                  state_d = FAULT;
               end
            end else begin
               state_d = PLL_RST;
            end
         end
         default: ;
      endcase

      pll_rst_d   = (state_d == PLL_RST) || (state_d == FAULT);
      extswitch_d = (state_d == SWITCH);
      fault_d     = (state_d == FAULT);
      for (int i = 0; i < N_DOM; i++) begin
         dom_d[i] = (state_d == RUN) || ((state_d == RELEASE) && (4'(i) < rel_d));
      end
   end

   assign state     = state_q;
   assign pll_rst   = pll_rst_q;
   assign extswitch = extswitch_q;
   assign clk_sel   = clk_sel_q;
   assign dom_rst_n = dom_q;
   assign retry_cnt = retry_q;
   assign loss_cnt  = loss_q;
   assign fault     = fault_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Directed bench for pll_supervisor with small timing parameters; a second instance
// has reference switching disabled and its lock input tied low.
module tb_pll_supervisor;

   logic        refclk = 1'b0;
   logic        rst_n;
   logic        pll_locked;
   logic        pll_rst, extswitch, clk_sel, fault;
   logic [2:0]  dom_rst_n, state;
   logic [3:0]  retry_cnt;
   logic [15:0] loss_cnt;

   logic        ns_pll_rst, ns_extswitch, ns_clk_sel, ns_fault;
   logic [2:0]  ns_dom_rst_n, ns_state;
   logic [3:0]  ns_retry_cnt;
   logic [15:0] ns_loss_cnt;

   int   checks    = 0;
   int   failures  = 0;
   int   sw_pulses = 0;
   int   sw_double = 0;
   int   ns_pulses = 0;
   logic sw_prev   = 1'b0;

   always #5 refclk = ~refclk;

   pll_supervisor #(
      .N_DOM(3), .RST_PULSE_CYC(4), .LOCK_TIMEOUT_CYC(20), .LOCK_STABLE_CYC(8),
      .LOSS_FILT_CYC(3), .SEQ_GAP_CYC(2), .MAX_RETRY(2), .SWITCH_EN(1)
   ) dut (
      .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked),
      .pll_rst(pll_rst), .extswitch(extswitch), .clk_sel(clk_sel),
      .dom_rst_n(dom_rst_n), .state(state), .retry_cnt(retry_cnt),
      .loss_cnt(loss_cnt), .fault(fault)
   );

   pll_supervisor #(
      .N_DOM(3), .RST_PULSE_CYC(4), .LOCK_TIMEOUT_CYC(20), .LOCK_STABLE_CYC(8),
      .LOSS_FILT_CYC(3), .SEQ_GAP_CYC(2), .MAX_RETRY(2), .SWITCH_EN(0)
   ) dut_ns (
      .refclk(refclk), .rst_n(rst_n), .pll_locked(1'b0),
      .pll_rst(ns_pll_rst), .extswitch(ns_extswitch), .clk_sel(ns_clk_sel),
      .dom_rst_n(ns_dom_rst_n), .state(ns_state), .retry_cnt(ns_retry_cnt),
      .loss_cnt(ns_loss_cnt), .fault(ns_fault)
   );

   always @(negedge refclk) begin
      sw_prev <= extswitch;
      if (extswitch && sw_prev) sw_double <= sw_double + 1;
      if (extswitch) sw_pulses <= sw_pulses + 1;
      if (ns_extswitch) ns_pulses <= ns_pulses + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge refclk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
   endtask

   task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
      int n = 0;
      while (state !== st && n < budget) begin
         step(1);
         n++;
      end
      chk(tag, 32'(state), 32'(st));
   endtask

   initial begin
      int   base;
      logic saw_rel;
      rst_n      = 1'b1;
      pll_locked = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_pll_rst", 32'(pll_rst), 32'd1);
      chk("rst_dom", 32'(dom_rst_n), 32'd0);
      chk("rst_misc", 32'({extswitch, clk_sel, fault, retry_cnt, loss_cnt}), 32'd0);
      step(2);
      rst_n = 1'b1;

      // Nominal bring-up with lock held high
      step(3);
      chk("nom_pll_rst_hi", 32'(pll_rst), 32'd1);
      chk("nom_state_rst", 32'(state), 32'd0);
      step(1);
      chk("nom_pll_rst_lo", 32'(pll_rst), 32'd0);
      chk("nom_state_wait", 32'(state), 32'd1);
      step(1);
      chk("nom_state_stable", 32'(state), 32'd2);
      chk("nom_dom_000", 32'(dom_rst_n), 32'd0);
      step(8);
      chk("nom_state_release", 32'(state), 32'd3);
      chk("nom_dom_001", 32'(dom_rst_n), 32'd1);
      step(1);
      chk("nom_dom_001_hold", 32'(dom_rst_n), 32'd1);
      step(1);
      chk("nom_dom_011", 32'(dom_rst_n), 32'd3);
      step(2);
      chk("nom_dom_111", 32'(dom_rst_n), 32'd7);
      chk("nom_state_run", 32'(state), 32'd4);
      chk("nom_retry", 32'(retry_cnt), 32'd0);

      // Two-cycle glitch is filtered out
      pll_locked = 1'b0;
      step(2);
      pll_locked = 1'b1;
      step(4);
      chk("glitch_state", 32'(state), 32'd4);
      chk("glitch_dom", 32'(dom_rst_n), 32'd7);
      chk("glitch_loss", 32'(loss_cnt), 32'd0);

      // Three-cycle low is a lock loss
      pll_locked = 1'b0;
      step(3);
      pll_locked = 1'b1;
      step(1);
      chk("loss_pre_state", 32'(state), 32'd4);
      step(1);
      chk("loss_state", 32'(state), 32'd0);
      chk("loss_dom", 32'(dom_rst_n), 32'd0);
      chk("loss_cnt", 32'(loss_cnt), 32'd1);
      chk("loss_clk_sel", 32'(clk_sel), 32'd0);
      chk("loss_pll_rst", 32'(pll_rst), 32'd1);

      // Relock, then reset asynchronously in the middle of RELEASE
      base = sw_pulses;
      wait_state(3'd3, 40, "relock_release");
      chk("relock_dom_001", 32'(dom_rst_n), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      chk("async_state", 32'(state), 32'd0);
      chk("async_pll_rst", 32'(pll_rst), 32'd1);
      chk("async_dom", 32'(dom_rst_n), 32'd0);
      chk("async_misc", 32'({extswitch, clk_sel, fault, retry_cnt, loss_cnt}), 32'd0);
      step(1);
      rst_n = 1'b1;
      step(3);
      chk("restart_pll_rst", 32'(pll_rst), 32'd1);
      step(1);
      chk("restart_wait", 32'(state), 32'd1);
      chk("restart_no_switch", 32'(sw_pulses), 32'(base));

      // Lock stuck low: two timeouts, then a single switch pulse
      pll_locked = 1'b0;
      do_reset();
      step(23);
      chk("sw_wait1", 32'(state), 32'd1);
      chk("sw_retry0", 32'(retry_cnt), 32'd0);
      step(1);
      chk("sw_fail1_state", 32'(state), 32'd0);
      chk("sw_fail1_retry", 32'(retry_cnt), 32'd1);
      step(24);
      chk("sw_state", 32'(state), 32'd5);
      chk("sw_extswitch", 32'(extswitch), 32'd1);
      chk("sw_clk_sel", 32'(clk_sel), 32'd1);
      chk("sw_retry", 32'(retry_cnt), 32'd0);
      chk("ns_fault_state", 32'(ns_state), 32'd6);
      chk("ns_fault", 32'(ns_fault), 32'd1);
      step(1);
      chk("sw_after_state", 32'(state), 32'd0);
      chk("sw_after_ext", 32'(extswitch), 32'd0);
      chk("sw_after_clk_sel", 32'(clk_sel), 32'd1);
      chk("sw_pulse_count", 32'(sw_pulses), 32'(base + 1));
      pll_locked = 1'b1;
      wait_state(3'd4, 60, "sw_run");
      chk("sw_run_dom", 32'(dom_rst_n), 32'd7);
      chk("sw_run_clk_sel", 32'(clk_sel), 32'd1);

      // Both references fail: fault is terminal and ignores later lock
      base = sw_pulses;
      pll_locked = 1'b0;
      do_reset();
      step(97);
      chk("flt_state", 32'(state), 32'd6);
      chk("flt_fault", 32'(fault), 32'd1);
      chk("flt_retry", 32'(retry_cnt), 32'd2);
      chk("flt_clk_sel", 32'(clk_sel), 32'd1);
      chk("flt_pll_rst", 32'(pll_rst), 32'd1);
      chk("flt_dom", 32'(dom_rst_n), 32'd0);
      chk("flt_pulses", 32'(sw_pulses), 32'(base + 1));
      pll_locked = 1'b1;
      step(20);
      chk("flt_hold_state", 32'(state), 32'd6);
      chk("flt_hold_fault", 32'(fault), 32'd1);
      chk("flt_hold_dom", 32'(dom_rst_n), 32'd0);

      // Lock toggling every 5 cycles never qualifies
      do_reset();
      saw_rel = 1'b0;
      for (int k = 0; k < 70; k++) begin
         pll_locked = ((k / 5) % 2 == 0);
         step(1);
         if (state == 3'd3 || state == 3'd4) saw_rel = 1'b1;
      end
      chk("unstable_no_release", 32'(saw_rel), 32'd0);
      chk("unstable_retry", 32'(retry_cnt), 32'd1);

      chk("ns_never_switched", 32'(ns_pulses), 32'd0);
      chk("ext_never_double", 32'(sw_double), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
